axi_burst_slave_mem: RTL and testbench

AXI4 burst responder with a local word-addressed memory. It is the slave end for AXI_memory_master_burst. It accepts write bursts on AW/W and returns B, and it serves read bursts on AR by driving R and generating rlast itself. Write and read paths are independent FSMs sharing one memory array; it replaces the ad-hoc slave models in the master benches and serves as the on-chip scratch memory.

---
 rtl/axi_burst_slave_mem_if.sv | 56 +++++
 rtl/axi_burst_slave_mem.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_burst_slave_mem.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_slave_mem_if.sv
// AXI4 burst bus between a master and axi_burst_slave_mem.
// Carries the AW, W, B, AR and R channels. Widths come from the parameters,
// which must match those of the slave that is attached.
interface axi_burst_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_slave_mem.sv
// AXI4 burst slave with a local word-addressed memory.
// Ports: clk, reset (sync, active high), bus (slave modport: AW/W/B write
// path, AR/R read path). Write and read paths are independent FSMs sharing
// one memory; all bus outputs are registered.
module axi_burst_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 128
) (
  input logic                 clk,
  input logic                 reset,
  axi_burst_slave_mem_if.slave bus
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned SHIFT  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Write path state
  logic [1:0]            w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic                  wfixed_q, wfixed_d;
  logic                  willeg_q, willeg_d;
  logic                  werr_q, werr_d;
  logic                  w_beat_c, w_oor_c, w_last_c, mem_we_c;

  // Read path state
  logic [0:0]            r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] ridx_q, ridx_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic                  rfixed_q, rfixed_d;
  logic                  rilleg_q, rilleg_d;
  logic                  r_load_c, r_oor_c;

  assign w_beat_c = (w_state_q == W_DATA) && bus.wvalid && wready_q;
  assign w_oor_c  = (widx_q >= DEPTH_A);
  assign w_last_c = (wcnt_q == wlen_q);
  // Illegal bursts and out-of-range beats never touch the array; reset drops the beat.
  assign mem_we_c = w_beat_c && !w_oor_c && !willeg_q && !reset;

  // Write FSM next state
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wfixed_d  = wfixed_q;
    willeg_d  = willeg_q;
    werr_d    = werr_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (bus.awvalid && awready_q) begin
          wid_d     = bus.awid;
          widx_d    = bus.awaddr >> SHIFT;
          wlen_d    = bus.awlen;
          wcnt_d    = 8'd0;
          wfixed_d  = (bus.awburst == BURST_FIXED);
          willeg_d  = (bus.awburst != BURST_FIXED) && (bus.awburst != BURST_INCR);
          werr_d    = willeg_d;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_beat_c) begin
          // awlen alone sets the beat count; a wrong wlast only flags the error.
          if (w_oor_c || willeg_q || (bus.wlast != w_last_c)) werr_d = 1'b1;
          if (!wfixed_q) widx_d = widx_q + ADDR_WIDTH'(1);
          if (w_last_c) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = wid_q;
            bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bus.bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 8'd0;
      wfixed_q  <= 1'b0;
      willeg_q  <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wfixed_q  <= wfixed_d;
      willeg_q  <= willeg_d;
      werr_q    <= werr_d;
    end
  end

  // Byte-enabled memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) mem_q[widx_q[IDX_W-1:0]][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM next state; each new beat is fetched into rdata_q one edge ahead
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rfixed_d  = rfixed_q;
    rilleg_d  = rilleg_q;
    r_load_c  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (bus.arvalid && arready_q) begin
          rid_d     = bus.arid;
          ridx_d    = bus.araddr >> SHIFT;
          rlen_d    = bus.arlen;
          rcnt_d    = 8'd0;
          rfixed_d  = (bus.arburst == BURST_FIXED);
          rilleg_d  = (bus.arburst != BURST_FIXED) && (bus.arburst != BURST_INCR);
          rvalid_d  = 1'b1;
          rlast_d   = (bus.arlen == 8'd0);
          arready_d = 1'b0;
          r_load_c  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.rready && rvalid_q) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rcnt_d   = rcnt_q + 8'd1;
            if (!rfixed_q) ridx_d = ridx_q + ADDR_WIDTH'(1);
            rlast_d  = (rcnt_d == rlen_q);
            r_load_c = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_oor_c = (ridx_d >= DEPTH_A);
    if (r_load_c) begin
      rdata_d = r_oor_c ? '0 : mem_q[ridx_d[IDX_W-1:0]];
      rresp_d = (r_oor_c || rilleg_d) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read FSM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      ridx_q    <= '0;
      rlen_q    <= 8'd0;
      rcnt_q    <= 8'd0;
      rfixed_q  <= 1'b0;
      rilleg_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rfixed_q  <= rfixed_d;
      rilleg_q  <= rilleg_d;
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Self-checking bench for axi_burst_slave_mem: directed scenarios followed by
// randomized bursts, all checked against a word-array model of the memory.
module tb_axi_burst_slave_mem;
  localparam int unsigned DEPTH = 128;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] last_rdata;
  logic [1:0]  last_bresp;

  axi_burst_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi_burst_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full write burst from wd/ws; bad_beat (-1 = none) gets an inverted wlast.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int bad_beat, input int bdelay);
    int n;
    logic err, ill;
    logic [31:0] idx;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    check("aw_ready_wait", 64'(bus.awready), 64'd1);
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
    bus.awlen = 8'(len); bus.awburst = burst;
    @(negedge clk);
    bus.awvalid = 1'b0;
    ill = (burst > 2'b01);
    err = ill;
    idx = addr >> 2;
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i];
      bus.wlast = (i == len) ^ (i == bad_beat);
      check("w_ready", 64'(bus.wready), 64'd1);
      if (i == bad_beat) err = 1'b1;
      if (ill || idx >= DEPTH) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (ws[i][b]) mem_m[idx][b*8 +: 8] = wd[i][b*8 +: 8];
      if (burst != 2'b00) idx = idx + 1;
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("w_ready_off", 64'(bus.wready), 64'd0);
    for (int d = 0; d < bdelay; d++) begin
      check("b_hold", 64'(bus.bvalid), 64'd1);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    check("b_valid", 64'(bus.bvalid), 64'd1);
    check("b_id", 64'(bus.bid), 64'(id));
    check("b_resp", 64'(bus.bresp), err ? 64'd2 : 64'd0);
    last_bresp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_valid_off", 64'(bus.bvalid), 64'd0);
    check("aw_ready_back", 64'(bus.awready), 64'd1);
  endtask

  // Read burst; mode 0 rready=1, 1 pattern 1,0,0, 2 random.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int mode);
    int n, beats, cyc, phase;
    logic ill, rr;
    logic [31:0] idx;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    check("ar_ready_wait", 64'(bus.arready), 64'd1);
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
    bus.arlen = 8'(len); bus.arburst = burst;
    @(negedge clk);
    bus.arvalid = 1'b0;
    ill = (burst > 2'b01);
    idx = addr >> 2;
    beats = 0; cyc = 0; phase = 0;
    while (beats <= len && cyc < 8 * (len + 1) + 16) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (phase % 3 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      phase++;
      bus.rready = rr;
      check("r_valid", 64'(bus.rvalid), 64'd1);
      check("r_id", 64'(bus.rid), 64'(id));
      check("r_resp", 64'(bus.rresp), (ill || idx >= DEPTH) ? 64'd2 : 64'd0);
      check("r_last", 64'(bus.rlast), 64'(beats == len));
      if (!ill) check("r_data", 64'(bus.rdata), (idx >= DEPTH) ? 64'd0 : 64'(mem_m[idx[6:0]]));
      last_rdata = bus.rdata;
      @(negedge clk);
      cyc++;
      if (rr) begin
        beats++;
        if (burst != 2'b00) idx = idx + 1;
      end
    end
    bus.rready = 1'b0;
    check("r_beats", 64'(beats), 64'(len + 1));
    check("r_valid_off", 64'(bus.rvalid), 64'd0);
    check("r_last_off", 64'(bus.rlast), 64'd0);
    check("ar_ready_back", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    int len, r, bad;
    logic [31:0] addr;
    logic [1:0] burst;
    reset = 1'b1;
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0;
    bus.rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rlast", 64'(bus.rlast), 64'd0);
    check("rst_bid_rid", {56'd0, bus.bid, bus.rid}, 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_resp", {60'd0, bus.bresp, bus.rresp}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_awready", 64'(bus.awready), 64'd1);
    check("rel_arready", 64'(bus.arready), 64'd1);

    // Give every word a known value
    for (int i = 0; i < 128; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'h0, 32'h0, 127, 2'b01, -1, 0);

    // INCR write 10..17, read back
    for (int i = 0; i < 8; i++) begin wd[i] = 32'(10 + i); ws[i] = 4'hF; end
    do_write(4'hA, 32'h0, 7, 2'b01, -1, 0);
    check("incr_bresp", 64'(last_bresp), 64'd0);
    do_read(4'hA, 32'h0, 7, 2'b01, 0);
    check("incr_last_data", 64'(last_rdata), 64'd17);

    // rready 1,0,0 stalls
    do_read(4'h3, 32'h0, 3, 2'b01, 1);

    // Crossing the top of memory
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'h5, 32'h1F8, 3, 2'b01, -1, 2);
    check("oor_bresp", 64'(last_bresp), 64'd2);
    do_read(4'h6, 32'h1F8, 3, 2'b01, 0);

    // FIXED write, then partial strobe
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    do_write(4'h1, 32'h10, 2, 2'b00, -1, 0);
    do_read(4'h1, 32'h10, 0, 2'b01, 0);
    check("fixed_word", 64'(last_rdata), 64'd3);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0011;
    do_write(4'h2, 32'h10, 0, 2'b00, -1, 0);
    do_read(4'h2, 32'h10, 0, 2'b01, 0);
    check("strb_word", 64'(last_rdata), 64'h0000CCDD);

    // Early wlast
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'h7, 32'h40, 3, 2'b01, 2, 0);
    check("wlast_bresp", 64'(last_bresp), 64'd2);
    do_read(4'h7, 32'h40, 3, 2'b01, 0);

    // Reset in the middle of a read
    bus.arvalid = 1'b1; bus.arid = 4'h9; bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arburst = 2'b01;
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
    @(negedge clk);
    bus.rready = 1'b0;
    check("mid_rst_arready", 64'(bus.arready), 64'd1);
    check("mid_rst_rvalid2", 64'(bus.rvalid), 64'd0);

    // Concurrent AW and AR on disjoint words
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_write(4'hB, 32'h80, 3, 2'b01, -1, 0);
      do_read(4'hC, 32'h100, 3, 2'b01, 0);
    join

    // Randomized bursts
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(0, 15);
      r = $urandom_range(0, 7);
      if (r == 0) addr = 32'h1C0 + 32'($urandom_range(0, 63));
      else if (r == 1) addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
      else addr = 32'($urandom_range(0, 127) * 4 + $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      burst = (r < 3) ? 2'b00 : (r < 9) ? 2'b01 : 2'($urandom_range(2, 3));
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(4'($urandom), addr, len, burst, bad, $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      burst = (r < 3) ? 2'b00 : (r < 9) ? 2'b01 : 2'b11;
      do_read(4'($urandom), addr, len, burst, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
